// File: rtl/mux_select_scanner.sv
// Purpose : steps the S1/S0 select lines of a 4-to-1 mux across channels 0..3,
//           samples Y once per channel after it settles, and presents the four
//           samples as a 4-bit snapshot.
// Latency : each channel takes SETTLE_CYCLES+1 cycles. snap_valid is high after
//           edge E0+4*(SETTLE_CYCLES+1), where E0 is the edge that accepts start.
// Backpressure: snapshot and snap_valid hold in PRESENT until snap_valid &&
//           snap_ready at an edge. No new scan starts until that handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begins a scan; sampled only in IDLE
//   continuous        1 = start the next scan straight after each handshake
//   abort             synchronous return to IDLE; drops any pending snapshot
//   y_in              Y output of the mux
//   s1, s0            registered mux select
//   busy              high in every state except IDLE
//   snapshot          bit i = Y sampled while {s1,s0} == i
//   snap_valid/ready  snapshot handshake
//   changed           snapshot differs from the last accepted one
//
// Build option: define CHANGE_DETECT_EN to build the change detector. Without
// it, changed is tied low and no history register exists.
module mux_select_scanner #(
  parameter int SETTLE_CYCLES = 2,  // legal range 1..15
  parameter int CNT_W         = 4   // must hold SETTLE_CYCLES-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       y_in,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic [3:0] snapshot,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic       changed
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLE  = 2'd2,
    PRESENT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       ch;
  logic [CNT_W-1:0] cnt;
  // Samples of channels 0..2; channel 3 goes straight from y_in into snapshot.
  logic [2:0]       shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch         <= 2'd0;
      cnt        <= '0;
      shadow     <= 3'b000;
      s1         <= 1'b0;
      s0         <= 1'b0;
      busy       <= 1'b0;
      snapshot   <= 4'b0000;
      snap_valid <= 1'b0;
    end else if (abort) begin
      // Abort overrides everything, including a start in IDLE. The last
      // snapshot value is kept on the bus, only its valid is dropped.
      state      <= IDLE;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      {s1, s0}   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch       <= 2'd0;
            {s1, s0} <= 2'b00;
            cnt      <= CNT_RELOAD;
            busy     <= 1'b1;
            state    <= SETTLE;
          end
        end

        SETTLE: begin
          // Counter runs from SETTLE_CYCLES-1 down to 0, so SETTLE lasts
          // exactly SETTLE_CYCLES cycles.
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SAMPLE: begin
          if (ch != 2'd3) begin
            case (ch)
              2'd0:    shadow[0] <= y_in;
              2'd1:    shadow[1] <= y_in;
              default: shadow[2] <= y_in;
            endcase
            ch       <= ch + 2'd1;
            {s1, s0} <= ch + 2'd1;
            cnt      <= CNT_RELOAD;
            state    <= SETTLE;
          end else begin
            snapshot   <= {y_in, shadow};
            snap_valid <= 1'b1;
            state      <= PRESENT;
          end
        end

        PRESENT: begin
          if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
            {s1, s0}   <= 2'b00;
            if (continuous) begin
              // Back-to-back scan: go straight to settling channel 0.
              ch    <= 2'd0;
              cnt   <= CNT_RELOAD;
              state <= SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CHANGE_DETECT_EN
  // prev holds the last snapshot the consumer actually accepted, so an
  // aborted snapshot never becomes the reference for the next comparison.
  logic [3:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 4'b0000;
      changed <= 1'b0;
    end else if (abort) begin
      changed <= 1'b0;
    end else if (state == SAMPLE && ch == 2'd3) begin
      changed <= ({y_in, shadow} != prev);
    end else if (state == PRESENT && snap_valid && snap_ready) begin
      changed <= 1'b0;
      prev    <= snapshot;
    end
  end
`else
  assign changed = 1'b0;
`endif

endmodule
